cmp_seq: RTL and testbench

- Iterative, parametrised magnitude comparator. Successor to the combinational `cmp` (SIZE_ wide, gt_ only).
- Compares two SIZE_-bit operands CHUNK_ bits per cycle, MSB chunk first, and stops early at the first differing chunk.
- Supports signed/unsigned operands and six selectable relations, with a start/busy/done handshake.
- Feeds the iterative datapaths of the factorial engine, which reuse one narrow comparator across multiple cycles.

---
 rtl/cmp_seq_pkg.sv | 39 +++
 rtl/cmp_seq_cmp.sv | 12 +
 rtl/cmp_seq.sv | 101 ++++++++++
 tb/tb_cmp_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_seq_pkg.sv
// Shared definitions for the iterative comparator: FSM states, relation codes,
// chunk-count helpers and the relation decode.
package cmp_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [2:0] CMP_GT = 3'd0;
    localparam logic [2:0] CMP_GE = 3'd1;
    localparam logic [2:0] CMP_LT = 3'd2;
    localparam logic [2:0] CMP_LE = 3'd3;
    localparam logic [2:0] CMP_EQ = 3'd4;
    localparam logic [2:0] CMP_NE = 3'd5;

    function automatic int nchunk(input int size, input int chunk);
        return (size + chunk - 1) / chunk;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Codes 6 and 7 are reserved and always evaluate false.
    function automatic logic mode_result(input logic [2:0] mode, input logic gt,
                                         input logic eq, input logic lt);
        case (mode)
            CMP_GT:  return gt;
            CMP_GE:  return gt | eq;
            CMP_LT:  return lt;
            CMP_LE:  return lt | eq;
            CMP_EQ:  return eq;
            CMP_NE:  return ~eq;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_seq_cmp.sv
// Combinational unsigned greater-than unit, used by cmp_seq once per chunk.
module cmp #(
    parameter int SIZE_ = 8
) (
    input  logic [SIZE_-1:0] a_,
    input  logic [SIZE_-1:0] b_,
    output logic             gt_
);

    assign gt_ = (a_ > b_);

endmodule

// File: rtl/cmp_seq.sv
// Iterative magnitude comparator: scans CHUNK_ bits per cycle from the MSB end
// and resolves on the first differing chunk, with a start/busy/done handshake.
module cmp_seq
    import cmp_seq_pkg::*;
#(
    parameter int SIZE_   = 8,
    parameter int CHUNK_  = 2,
    parameter int SIGNED_ = 0
) (
    input  logic             clk_,
    input  logic             rst_,
    input  logic             start_,
    input  logic [SIZE_-1:0] a_,
    input  logic [SIZE_-1:0] b_,
    input  logic [2:0]       mode_,
    output logic             busy_,
    output logic             done_,
    output logic             result_,
    output logic             gt_,
    output logic             eq_,
    output logic             lt_
);

    localparam int NCHUNK = nchunk(SIZE_, CHUNK_);
    localparam int PW     = NCHUNK * CHUNK_;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0]    LAST  = IW'(NCHUNK - 1);
    localparam logic [SIZE_-1:0] SFLIP = (SIGNED_ != 0) ? (SIZE_'(1) << (SIZE_ - 1)) : '0;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   ra;
    logic [PW-1:0]   rb;
    logic [2:0]      rmode;
    logic [CHUNK_-1:0] ca;
    logic [CHUNK_-1:0] cb;
    logic            cgt;
    logic            ceq;
    logic            clt;

    // Operands shift up one chunk per step, so the chunk under test is always
    // the top one; idx only counts steps to detect the last chunk.
    assign ca = ra[PW-1 -: CHUNK_];
    assign cb = rb[PW-1 -: CHUNK_];

    cmp #(.SIZE_(CHUNK_)) u_chunk_gt (
        .a_ (ca),
        .b_ (cb),
        .gt_(cgt)
    );

    assign ceq = (ca == cb);
    assign clt = ~ceq & ~cgt;

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            state   <= IDLE;
            idx     <= '0;
            ra      <= '0;
            rb      <= '0;
            rmode   <= '0;
            busy_   <= 1'b0;
            done_   <= 1'b0;
            result_ <= 1'b0;
            gt_     <= 1'b0;
            eq_     <= 1'b0;
            lt_     <= 1'b0;
        end else begin
            done_ <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_) begin
                        ra    <= PW'(a_ ^ SFLIP);
                        rb    <= PW'(b_ ^ SFLIP);
                        rmode <= mode_;
                        idx   <= '0;
                        busy_ <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!ceq || idx == LAST) begin
                        gt_     <= cgt;
                        eq_     <= ceq;
                        lt_     <= clt;
                        result_ <= mode_result(rmode, cgt, ceq, clt);
                        done_   <= 1'b1;
                        busy_   <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                        ra  <= ra << CHUNK_;
                        rb  <= rb << CHUNK_;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq.sv
// Directed and exhaustive bench for cmp_seq across six parameter sets driven in
// lock-step from shared inputs.
module tb_cmp_seq;
    import cmp_seq_pkg::*;

    typedef struct packed {
        logic       res;
        logic       gt;
        logic       eq;
        logic       lt;
        logic [3:0] lat;
    } one_t;
    typedef one_t [5:0] all_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] mode = '0;
    logic [5:0] busy, done, res, gt, eq, lt;

    int    checks = 0;
    int    errors = 0;
    all_t  sb[$];
    int    got_lat[6];
    int    got_dn[6];
    logic  got_res[6], got_gt[6], got_eq[6], got_lt[6];
    string ctx = "";
    int    ndone;

    always #5 clk = ~clk;

    // d0:8/2/u d1:8/2/s d2:5/2/u d3:5/2/s d4:4/4/u d5:4/4/s
    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int S  = (g < 2) ? 8 : ((g < 4) ? 5 : 4);
        localparam int C  = (g < 4) ? 2 : 4;
        localparam int SG = g % 2;
        cmp_seq #(.SIZE_(S), .CHUNK_(C), .SIGNED_(SG)) u_dut (
            .clk_   (clk),
            .rst_   (rst),
            .start_ (start),
            .a_     (a[S-1:0]),
            .b_     (b[S-1:0]),
            .mode_  (mode),
            .busy_  (busy[g]),
            .done_  (done[g]),
            .result_(res[g]),
            .gt_    (gt[g]),
            .eq_    (eq[g]),
            .lt_    (lt[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: observed %0h expected %0h", ctx, tag, obs, exp);
        end
    endtask

    function automatic one_t model(input int i, input logic [7:0] ta, input logic [7:0] tb,
                                   input logic [2:0] m);
        one_t r;
        int s, c, n, ua, ub, va, vb, oa, ob, lat;
        bit found;
        s  = (i < 2) ? 8 : ((i < 4) ? 5 : 4);
        c  = (i < 4) ? 2 : 4;
        n  = (s + c - 1) / c;
        ua = int'(ta) & ((1 << s) - 1);
        ub = int'(tb) & ((1 << s) - 1);
        va = ua;
        vb = ub;
        oa = ua;
        ob = ub;
        if (i % 2 == 1) begin
            if (ua >= (1 << (s - 1))) va = ua - (1 << s);
            if (ub >= (1 << (s - 1))) vb = ub - (1 << s);
            oa = ua ^ (1 << (s - 1));
            ob = ub ^ (1 << (s - 1));
        end
        r.gt = (va > vb);
        r.eq = (va == vb);
        r.lt = (va < vb);
        lat = n;
        found = 0;
        for (int k = 0; k < n; k++) begin
            if (!found && (((oa >> ((n - 1 - k) * c)) & ((1 << c) - 1)) !=
                           ((ob >> ((n - 1 - k) * c)) & ((1 << c) - 1)))) begin
                lat = k + 1;
                found = 1;
            end
        end
        r.lat = 4'(lat);
        case (m)
            3'd0: r.res = r.gt;
            3'd1: r.res = r.gt | r.eq;
            3'd2: r.res = r.lt;
            3'd3: r.res = r.lt | r.eq;
            3'd4: r.res = r.eq;
            3'd5: r.res = ~r.eq;
            default: r.res = 1'b0;
        endcase
        return r;
    endfunction

    task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] tm);
        all_t e;
        for (int i = 0; i < 6; i++) e[i] = model(i, ta, tb, tm);
        sb.push_back(e);
        @(negedge clk);
        a = ta; b = tb; mode = tm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            got_dn[i] = 0;
            got_lat[i] = 0;
        end
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (done[i]) begin
                    got_dn[i]++;
                    if (got_dn[i] == 1) begin
                        got_lat[i] = j;
                        got_res[i] = res[i];
                        got_gt[i]  = gt[i];
                        got_eq[i]  = eq[i];
                        got_lt[i]  = lt[i];
                    end
                end
            end
        end
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            ctx = $sformatf("d%0d a=%0h b=%0h m=%0d", i, ta, tb, tm);
            chk("ndone", got_dn[i], 1);
            chk("lat", got_lat[i], 32'(e[i].lat));
            chk("res", got_res[i], e[i].res);
            chk("gt", got_gt[i], e[i].gt);
            chk("eq", got_eq[i], e[i].eq);
            chk("lt", got_lt[i], e[i].lt);
        end
        ctx = "";
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", {gt, eq, lt}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned early exit
        run_cmp(8'h80, 8'h7F, CMP_GT);
        ctx = "t1 d0";
        chk("lat", got_lat[0], 1);
        chk("res", got_res[0], 1);
        chk("flags", {got_gt[0], got_eq[0], got_lt[0]}, 3'b100);

        // Full scan on equal operands
        run_cmp(8'h5A, 8'h5A, CMP_EQ);
        ctx = "t2eq d0";
        chk("lat", got_lat[0], 4);
        chk("res", got_res[0], 1);
        chk("flags", {got_gt[0], got_eq[0], got_lt[0]}, 3'b010);
        run_cmp(8'h5A, 8'h5A, CMP_NE);
        ctx = "t2ne d0";
        chk("res", got_res[0], 0);

        // Signed vs unsigned view of the same operands
        run_cmp(8'h80, 8'h01, CMP_LT);
        ctx = "t3 d1";
        chk("res", got_res[1], 1);
        chk("lt", got_lt[1], 1);
        ctx = "t3 d0";
        chk("res", got_res[0], 0);
        chk("gt", got_gt[0], 1);

        // Handshake: start while busy is dropped, start during done is taken
        ctx = "hs d0";
        @(negedge clk);
        a = 8'd3; b = 8'd2; mode = CMP_GT; start = 1'b1;
        @(negedge clk);
        chk("busy_after_accept", busy[0], 1);
        a = 8'd0; b = 8'd9;
        ndone = 0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            if (done[0]) ndone++;
            if (e == 1) start = 1'b0;
        end
        @(negedge clk);
        chk("first_done", done[0], 1);
        chk("first_gt", gt[0], 1);
        if (done[0]) ndone++;
        chk("single_done", ndone, 1);
        a = 8'h80; b = 8'h7F; mode = CMP_GT; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_back_to_back", busy[0], 1);
        chk("done_dropped", done[0], 0);
        @(negedge clk);
        chk("second_done", done[0], 1);
        chk("second_gt", gt[0], 1);
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-scan
        ctx = "rst_mid d0";
        a = 8'h11; b = 8'h11; mode = CMP_EQ; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("outs_cleared", {busy[0], done[0], res[0], gt[0], eq[0], lt[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("no_done_after_abort", ndone, 0);
        run_cmp(8'h11, 8'h11, CMP_EQ);
        ctx = "rst_mid d0";
        chk("restart_lat", got_lat[0], 4);
        chk("restart_res", got_res[0], 1);

        // Exhaustive over 5-bit operands and every mode code
        for (int ia = 0; ia < 32; ia++)
            for (int ib = 0; ib < 32; ib++)
                for (int im = 0; im < 8; im++)
                    run_cmp(8'(ia), 8'(ib), 3'(im));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
